// File: rtl/spi_rx.sv
// rtl/spi_rx.sv - SPI master receive shifter: MSB-first word assembly, valid/ready output, SCLK stall
module spi_rx #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic              rx_edge_i,
  input  logic              sdi_i,
  input  logic [LEN_W-1:0]  rx_len_i,
  input  logic              rx_len_updata_i,
  output logic              rx_done_o,
  output logic              rx_stall_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_data_vld_o,
  input  logic              rx_data_rdy_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, WAIT = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  bit_cnt_q, target_q;
  logic [DATA_W-1:0] shreg_q, out_q;
  logic              vld_q;

  logic              out_free, last_bit, word_end, bits_left;
  logic              start, sample, load_new, load_held;
  logic [DATA_W-1:0] shreg_nxt;

  assign out_free  = !vld_q || rx_data_rdy_i;
  assign last_bit  = (bit_cnt_q == target_q - LEN_W'(1));
  assign bits_left = (bit_cnt_q != target_q);
  assign word_end  = (bit_cnt_q[4:0] == 5'd31) || last_bit;
  assign shreg_nxt = {shreg_q[DATA_W-2:0], sdi_i};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en_i && (target_q != '0)) state_d = RECV;
      RECV: begin
        if (!en_i) begin
          state_d = IDLE;
        end else if (rx_edge_i && word_end) begin
          if (!out_free)     state_d = WAIT;
          else if (last_bit) state_d = IDLE;
        end
      end
      // A held word must be delivered before an abort can take effect.
      WAIT: if (out_free) state_d = bits_left ? RECV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start      = 1'b0;
    sample     = 1'b0;
    load_new   = 1'b0;
    load_held  = 1'b0;
    rx_done_o  = 1'b0;
    rx_stall_o = 1'b0;
    case (state_q)
      IDLE: start = en_i && (target_q != '0);
      RECV: begin
        sample    = en_i && rx_edge_i;
        rx_done_o = sample && last_bit;
        load_new  = sample && word_end && out_free;
      end
      WAIT: begin
        rx_stall_o = 1'b1;
        load_held  = out_free;
      end
      default: ;
    endcase
  end

  // The shifter is cleared whenever a word leaves it, so a short final word lands right-aligned.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      target_q  <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      out_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      if ((state_q == IDLE) && rx_len_updata_i) target_q <= rx_len_i;
      if (start) begin
        bit_cnt_q <= '0;
        shreg_q   <= '0;
      end
      if (sample) begin
        bit_cnt_q <= bit_cnt_q + LEN_W'(1);
        shreg_q   <= load_new ? '0 : shreg_nxt;
      end
      if (load_held) shreg_q <= '0;
      if (load_new)       out_q <= shreg_nxt;
      else if (load_held) out_q <= shreg_q;
      if (load_new || load_held) vld_q <= 1'b1;
      else if (rx_data_rdy_i)    vld_q <= 1'b0;
    end
  end

  assign rx_data_o     = out_q;
  assign rx_data_vld_o = vld_q;

endmodule
